// File: rtl/l2_reqs_buf_ctrl_pkg.sv
// l2_reqs_buf_pkg: field widths and the packed ongoing-request record
// shared by the L2 request buffer, its bus interface and its users.
package l2_reqs_buf_pkg;

  // Cache geometry and message field widths
  localparam int CPU_MSG_BITS          = 2;
  localparam int L2_TAG_BITS           = 13;
  localparam int L2_SET_BITS           = 8;
  localparam int L2_WAY_BITS           = 3;
  localparam int HSIZE_BITS            = 3;
  localparam int WORD_OFFSET_BITS      = 1;
  localparam int BYTE_OFFSET_BITS      = 3;
  localparam int UNSTABLE_STATE_BITS   = 4;
  localparam int HPROT_BITS            = 1;
  localparam int INVACK_CNT_CALC_WIDTH = 5;
  localparam int BITS_PER_WORD         = 64;
  localparam int BITS_PER_LINE         = 128;

  typedef enum logic [CPU_MSG_BITS-1:0] {
    CPU_READ       = 2'd0,
    CPU_READ_ATOM  = 2'd1,
    CPU_WRITE      = 2'd2,
    CPU_WRITE_ATOM = 2'd3
  } cpu_msg_t;

  // One outstanding L2 request; invack_cnt is a two's complement count
  typedef struct packed {
    cpu_msg_t                             cpu_msg;
    logic [L2_TAG_BITS-1:0]               tag;
    logic [L2_TAG_BITS-1:0]               tag_estall;
    logic [L2_SET_BITS-1:0]               set;
    logic [L2_WAY_BITS-1:0]               way;
    logic [HSIZE_BITS-1:0]                hsize;
    logic [WORD_OFFSET_BITS-1:0]          w_off;
    logic [BYTE_OFFSET_BITS-1:0]          b_off;
    logic [UNSTABLE_STATE_BITS-1:0]       state;
    logic [HPROT_BITS-1:0]                hprot;
    logic [INVACK_CNT_CALC_WIDTH-1:0]     invack_cnt;
    logic [BITS_PER_WORD-1:0]             word;
    logic [BITS_PER_LINE-1:0]             line;
  } reqs_entry_t;

  localparam int REQS_ENTRY_BITS = $bits(reqs_entry_t);

endpackage

// File: rtl/l2_reqs_buf_ctrl_if.sv
// l2_reqs_buf_ctrl_if: allocate / lookup / update / free / read bundle
// between the L2 front end and handlers (master) and the buffer (slave).
interface l2_reqs_buf_ctrl_if
  import l2_reqs_buf_pkg::*;
#(
  parameter int N_REQS   = 4,
  parameter int IDX_BITS = $clog2(N_REQS)
);
  logic                              alloc_valid;
  logic                              alloc_ready;
  reqs_entry_t                       alloc_entry;
  logic [IDX_BITS-1:0]               alloc_idx;
  logic [L2_TAG_BITS-1:0]            lookup_tag;
  logic [L2_SET_BITS-1:0]            lookup_set;
  logic                              lookup_hit;
  logic [IDX_BITS-1:0]               lookup_hit_idx;
  logic                              lookup_set_conflict;
  logic                              upd_valid;
  logic [IDX_BITS-1:0]               upd_idx;
  logic                              upd_state_en;
  logic [UNSTABLE_STATE_BITS-1:0]    upd_state;
  logic                              upd_line_en;
  logic [BITS_PER_LINE-1:0]          upd_line;
  logic                              upd_invack_en;
  logic [INVACK_CNT_CALC_WIDTH-1:0]  upd_invack_delta;
  logic                              free_valid;
  logic [IDX_BITS-1:0]               free_idx;
  logic [IDX_BITS-1:0]               rd_idx;
  reqs_entry_t                       rd_entry;
  logic                              rd_valid;
  logic [N_REQS-1:0]                 invack_done;
  logic [IDX_BITS:0]                 occupancy;
  logic                              err_free_invalid;

  modport master (
    output alloc_valid, alloc_entry, lookup_tag, lookup_set,
           upd_valid, upd_idx, upd_state_en, upd_state, upd_line_en, upd_line,
           upd_invack_en, upd_invack_delta, free_valid, free_idx, rd_idx,
    input  alloc_ready, alloc_idx, lookup_hit, lookup_hit_idx, lookup_set_conflict,
           rd_entry, rd_valid, invack_done, occupancy, err_free_invalid
  );

  modport slave (
    input  alloc_valid, alloc_entry, lookup_tag, lookup_set,
           upd_valid, upd_idx, upd_state_en, upd_state, upd_line_en, upd_line,
           upd_invack_en, upd_invack_delta, free_valid, free_idx, rd_idx,
    output alloc_ready, alloc_idx, lookup_hit, lookup_hit_idx, lookup_set_conflict,
           rd_entry, rd_valid, invack_done, occupancy, err_free_invalid
  );
endinterface

// File: rtl/l2_reqs_buf_ctrl_prio_enc.sv
// reqs_buf_prio_enc: lowest-set-bit priority encoder. idx is 0 when
// nothing is set; found qualifies it.
module reqs_buf_prio_enc #(
  parameter int WIDTH    = 4,
  parameter int IDX_BITS = 2
) (
  input  logic [WIDTH-1:0]    req,
  output logic                found,
  output logic [IDX_BITS-1:0] idx
);
  // Scan high to low so the lowest set bit is the last one written
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IDX_BITS'(i);
      end
    end
  end
endmodule

// File: rtl/l2_reqs_buf_ctrl.sv
// l2_reqs_buf_ctrl: N-entry L2 ongoing-request buffer (MSHR) with
// allocate, tag/set lookup, per-field update, free and inv-ack tracking.
// Optional statistics outputs are built when REQS_BUF_STATS_EN is defined.
module l2_reqs_buf_ctrl
  import l2_reqs_buf_pkg::*;
#(
  parameter int N_REQS      = 4,
  parameter int TAG_BITS    = L2_TAG_BITS,
  parameter int SET_BITS    = L2_SET_BITS,
  parameter int INVACK_BITS = INVACK_CNT_CALC_WIDTH,
  parameter int IDX_BITS    = $clog2(N_REQS)
) (
  input  logic                   clk,
  input  logic                   rst,
  l2_reqs_buf_ctrl_if.slave      bus
`ifdef REQS_BUF_STATS_EN
  ,
  input  logic                   stat_clr,
  output logic [IDX_BITS:0]      stat_hwm,
  output logic [31:0]            stat_alloc_stall
`endif
);

  logic [N_REQS-1:0]   valid_reg;
  reqs_entry_t         entry_reg [N_REQS];
  logic [IDX_BITS:0]   occupancy_reg;
  logic                err_reg;

  logic [N_REQS-1:0]   free_vec;
  logic [N_REQS-1:0]   hit_vec;
  logic [N_REQS-1:0]   conflict_vec;
  logic                free_found;
  logic                hit_found;
  logic [IDX_BITS-1:0] free_slot;
  logic [IDX_BITS-1:0] hit_slot;
  logic                alloc_fire;
  logic                free_ok;

  // Free-slot choice sees registered valid bits only, so a slot freed
  // this cycle is offered no earlier than the next one.
  assign free_vec = ~valid_reg;

  reqs_buf_prio_enc #(.WIDTH(N_REQS), .IDX_BITS(IDX_BITS)) u_free_enc (
    .req   (free_vec),
    .found (free_found),
    .idx   (free_slot)
  );

  reqs_buf_prio_enc #(.WIDTH(N_REQS), .IDX_BITS(IDX_BITS)) u_hit_enc (
    .req   (hit_vec),
    .found (hit_found),
    .idx   (hit_slot)
  );

  assign alloc_fire = bus.alloc_valid && free_found;
  assign free_ok    = bus.free_valid && (int'(bus.free_idx) < N_REQS) && valid_reg[bus.free_idx];

  assign bus.alloc_ready         = free_found;
  assign bus.alloc_idx           = free_slot;
  assign bus.lookup_hit          = hit_found;
  assign bus.lookup_hit_idx      = hit_slot;
  assign bus.lookup_set_conflict = |conflict_vec;
  assign bus.occupancy           = occupancy_reg;
  assign bus.err_free_invalid    = err_reg;
  assign bus.rd_valid = (int'(bus.rd_idx) < N_REQS) ? valid_reg[bus.rd_idx] : 1'b0;
  assign bus.rd_entry = (int'(bus.rd_idx) < N_REQS) ? entry_reg[bus.rd_idx] : '0;

  for (genvar gi = 0; gi < N_REQS; gi++) begin : g_entry
    logic sel_alloc;
    logic sel_free;
    logic sel_upd;

    assign sel_alloc = alloc_fire && (free_slot == IDX_BITS'(gi));
    assign sel_free  = free_ok && (bus.free_idx == IDX_BITS'(gi));
    // A free of the same entry takes precedence over its update
    assign sel_upd   = bus.upd_valid && valid_reg[gi] && (bus.upd_idx == IDX_BITS'(gi)) && !sel_free;

    assign conflict_vec[gi] = valid_reg[gi] &&
                              (entry_reg[gi].set[SET_BITS-1:0] == bus.lookup_set[SET_BITS-1:0]);
    assign hit_vec[gi]      = conflict_vec[gi] &&
                              (entry_reg[gi].tag[TAG_BITS-1:0] == bus.lookup_tag[TAG_BITS-1:0]);
    assign bus.invack_done[gi] = valid_reg[gi] && (entry_reg[gi].invack_cnt == '0);

    // Entry storage: alloc writes a free slot, update edits a valid one
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        entry_reg[gi] <= '0;
        valid_reg[gi] <= 1'b0;
      end else begin
        if (sel_alloc) begin
          entry_reg[gi] <= bus.alloc_entry;
          valid_reg[gi] <= 1'b1;
        end else if (sel_upd) begin
          if (bus.upd_state_en) entry_reg[gi].state <= bus.upd_state;
          if (bus.upd_line_en)  entry_reg[gi].line  <= bus.upd_line;
          if (bus.upd_invack_en)
            entry_reg[gi].invack_cnt <= INVACK_BITS'(entry_reg[gi].invack_cnt + bus.upd_invack_delta);
        end
        if (sel_free) valid_reg[gi] <= 1'b0;
      end
    end
  end

  // Occupancy counter and one-cycle illegal-free flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occupancy_reg <= '0;
      err_reg       <= 1'b0;
    end else begin
      case ({alloc_fire, free_ok})
        2'b10:   occupancy_reg <= occupancy_reg + {{IDX_BITS{1'b0}}, 1'b1};
        2'b01:   occupancy_reg <= occupancy_reg - {{IDX_BITS{1'b0}}, 1'b1};
        default: occupancy_reg <= occupancy_reg;
      endcase
      err_reg <= bus.free_valid && !free_ok;
    end
  end

`ifdef REQS_BUF_STATS_EN
  logic [IDX_BITS:0] hwm_reg;
  logic [31:0]       stall_reg;

  assign stat_hwm         = hwm_reg;
  assign stat_alloc_stall = stall_reg;

  // High-water mark and saturating stall-cycle counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hwm_reg   <= '0;
      stall_reg <= '0;
    end else if (stat_clr) begin
      hwm_reg   <= '0;
      stall_reg <= '0;
    end else begin
      if (occupancy_reg > hwm_reg) hwm_reg <= occupancy_reg;
      if (bus.alloc_valid && !free_found && (stall_reg != 32'hFFFF_FFFF))
        stall_reg <= stall_reg + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l2_reqs_buf_ctrl.sv
// tb_l2_reqs_buf_ctrl: scoreboard bench for l2_reqs_buf_ctrl. The driver
// predicts each cycle's outputs from a slot-level model and queues them;
// a monitor pops and compares between clock edges.
module tb_l2_reqs_buf_ctrl;
  import l2_reqs_buf_pkg::*;

  localparam int N  = 4;
  localparam int IB = 2;
  localparam int IW = INVACK_CNT_CALC_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  l2_reqs_buf_ctrl_if #(.N_REQS(N), .IDX_BITS(IB)) bus ();

`ifdef REQS_BUF_STATS_EN
  logic          stat_clr = 1'b0;
  logic [IB:0]   stat_hwm;
  logic [31:0]   stat_alloc_stall;
`endif

  l2_reqs_buf_ctrl #(.N_REQS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef REQS_BUF_STATS_EN
    ,
    .stat_clr         (stat_clr),
    .stat_hwm         (stat_hwm),
    .stat_alloc_stall (stat_alloc_stall)
`endif
  );

  // Reference model: slot occupancy, stored records, unbounded inv-ack sums
  bit          m_valid [N];
  reqs_entry_t m_ent   [N];
  int          m_inv   [N];
  bit          m_err;

  typedef struct {
    string       name;
    int          occ;
    bit          ready;
    int          aidx;
    bit          hit;
    int          hidx;
    bit          conf;
    logic [N-1:0] done;
    bit          err;
    bit          rvalid;
    reqs_entry_t rent;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_ent[i]   = '0;
      m_inv[i]   = 0;
    end
    m_err = 1'b0;
  endfunction

  function automatic logic [IW-1:0] wrap_inv(int v);
    logic [31:0] t;
    t = v;
    return t[IW-1:0];
  endfunction

  function automatic int first_free();
    for (int i = 0; i < N; i++) if (!m_valid[i]) return i;
    return -1;
  endfunction

  function automatic exp_t predict(string name);
    exp_t e;
    int   ri;
    e.name = name;
    e.occ  = 0;
    for (int i = 0; i < N; i++) if (m_valid[i]) e.occ++;
    e.aidx  = first_free();
    e.ready = (e.aidx >= 0);
    e.hit   = 1'b0;
    e.hidx  = 0;
    e.conf  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (m_valid[i] && m_ent[i].set == bus.lookup_set) begin
        e.conf = 1'b1;
        if (!e.hit && m_ent[i].tag == bus.lookup_tag) begin
          e.hit  = 1'b1;
          e.hidx = i;
        end
      end
      e.done[i] = m_valid[i] && (wrap_inv(m_inv[i]) == '0);
    end
    e.err    = m_err;
    ri       = int'(bus.rd_idx);
    e.rvalid = m_valid[ri];
    e.rent   = m_ent[ri];
    e.rent.invack_cnt = wrap_inv(m_inv[ri]);
    return e;
  endfunction

  function automatic void model_step();
    int aidx;
    bit fire;
    bit fok;
    int fi;
    int ui;
    if (!rst) begin
      model_reset();
      return;
    end
    aidx = first_free();
    fire = bus.alloc_valid && (aidx >= 0);
    fi   = int'(bus.free_idx);
    ui   = int'(bus.upd_idx);
    fok  = bus.free_valid && m_valid[fi];
    if (bus.upd_valid && m_valid[ui] && !(fok && fi == ui)) begin
      if (bus.upd_state_en)  m_ent[ui].state = bus.upd_state;
      if (bus.upd_line_en)   m_ent[ui].line  = bus.upd_line;
      if (bus.upd_invack_en) m_inv[ui] += int'($signed(bus.upd_invack_delta));
    end
    if (fok) m_valid[fi] = 1'b0;
    if (fire) begin
      m_valid[aidx] = 1'b1;
      m_ent[aidx]   = bus.alloc_entry;
      m_inv[aidx]   = int'($signed(bus.alloc_entry.invack_cnt));
    end
    m_err = bus.free_valid && !fok;
  endfunction

  // Called right after inputs are driven: queue expectation, advance model
  task automatic tick(string name);
    exp_t e;
    if (!rst) model_reset();
    e = predict(name);
    exp_q.push_back(e);
    model_step();
  endtask

  task automatic idle();
    bus.alloc_valid      = 1'b0;
    bus.alloc_entry      = '0;
    bus.lookup_tag       = '0;
    bus.lookup_set       = '0;
    bus.upd_valid        = 1'b0;
    bus.upd_idx          = '0;
    bus.upd_state_en     = 1'b0;
    bus.upd_state        = '0;
    bus.upd_line_en      = 1'b0;
    bus.upd_line         = '0;
    bus.upd_invack_en    = 1'b0;
    bus.upd_invack_delta = '0;
    bus.free_valid       = 1'b0;
    bus.free_idx         = '0;
    bus.rd_idx           = '0;
  endtask

  function automatic reqs_entry_t mk(int tag, int set, int inv);
    reqs_entry_t e;
    e            = '0;
    e.cpu_msg    = cpu_msg_t'(CPU_MSG_BITS'($urandom_range(0, 3)));
    e.tag        = L2_TAG_BITS'(tag);
    e.tag_estall = L2_TAG_BITS'($urandom);
    e.set        = L2_SET_BITS'(set);
    e.way        = L2_WAY_BITS'($urandom);
    e.hsize      = HSIZE_BITS'($urandom);
    e.w_off      = WORD_OFFSET_BITS'($urandom);
    e.b_off      = BYTE_OFFSET_BITS'($urandom);
    e.state      = UNSTABLE_STATE_BITS'($urandom);
    e.hprot      = HPROT_BITS'($urandom);
    e.invack_cnt = wrap_inv(inv);
    e.word       = {$urandom, $urandom};
    e.line       = {$urandom, $urandom, $urandom, $urandom};
    return e;
  endfunction

  function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: compare queued expectations between the edges
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.name, "/occupancy"}, 256'(bus.occupancy), 256'(e.occ));
        chk({e.name, "/alloc_ready"}, 256'(bus.alloc_ready), 256'(e.ready));
        if (e.ready) chk({e.name, "/alloc_idx"}, 256'(bus.alloc_idx), 256'(e.aidx));
        chk({e.name, "/lookup_hit"}, 256'(bus.lookup_hit), 256'(e.hit));
        if (e.hit) chk({e.name, "/hit_idx"}, 256'(bus.lookup_hit_idx), 256'(e.hidx));
        chk({e.name, "/set_conflict"}, 256'(bus.lookup_set_conflict), 256'(e.conf));
        chk({e.name, "/invack_done"}, 256'(bus.invack_done), 256'(e.done));
        chk({e.name, "/err_free_invalid"}, 256'(bus.err_free_invalid), 256'(e.err));
        chk({e.name, "/rd_valid"}, 256'(bus.rd_valid), 256'(e.rvalid));
        if (e.rvalid) chk({e.name, "/rd_entry"}, 256'(bus.rd_entry), 256'(e.rent));
      end
    end
  end

  // Driver: directed scenarios, random traffic, mid-run reset
  initial begin
    idle();
    model_reset();
    rst = 1'b0;
    repeat (2) begin @(negedge clk); idle(); tick("reset"); end
    @(negedge clk); rst = 1'b1; idle(); tick("reset_release");

    for (int k = 0; k < 4; k++) begin
      @(negedge clk); idle();
      bus.alloc_valid = 1'b1;
      bus.alloc_entry = mk(16 + k, 5, 0);
      tick("fill");
    end
    @(negedge clk); idle(); bus.lookup_tag = 13'h12; bus.lookup_set = 8'd5; bus.rd_idx = 2'd2; tick("lookup_hit");
    @(negedge clk); idle(); bus.lookup_tag = 13'h99; bus.lookup_set = 8'd5; tick("lookup_conflict");
    @(negedge clk); idle(); bus.lookup_tag = 13'h12; bus.lookup_set = 8'd6; tick("lookup_miss");

    @(negedge clk); idle();
    bus.alloc_valid = 1'b1; bus.alloc_entry = mk(32, 5, 0);
    bus.free_valid = 1'b1; bus.free_idx = 2'd1;
    tick("full_free_alloc");
    @(negedge clk); bus.free_valid = 1'b0; tick("reuse_slot");
    @(negedge clk); idle(); bus.lookup_tag = 13'h20; bus.lookup_set = 8'd5; bus.rd_idx = 2'd1; tick("reuse_lookup");

    for (int k = 0; k < 3; k++) begin
      @(negedge clk); idle();
      bus.upd_valid = 1'b1; bus.upd_idx = 2'd0; bus.upd_invack_en = 1'b1;
      bus.upd_invack_delta = (k < 2) ? 5'h1F : 5'd2;
      bus.rd_idx = 2'd0;
      tick("invack_upd");
      @(negedge clk); idle(); bus.rd_idx = 2'd0; tick("invack_chk");
    end

    for (int k = 0; k < 4; k++) begin
      @(negedge clk); idle(); bus.free_valid = 1'b1; bus.free_idx = IB'(k); tick("drain");
    end
    @(negedge clk); idle(); bus.free_valid = 1'b1; bus.free_idx = 2'd3; tick("free_invalid");
    @(negedge clk); idle(); tick("err_pulse");
    @(negedge clk); idle(); tick("err_clear");

    for (int c = 0; c < 600; c++) begin
      @(negedge clk); idle();
      bus.rd_idx     = IB'($urandom_range(0, 3));
      bus.lookup_tag = L2_TAG_BITS'($urandom_range(0, 7));
      bus.lookup_set = L2_SET_BITS'($urandom_range(0, 3));
      bus.alloc_valid = 1'($urandom_range(0, 1));
      bus.alloc_entry = mk($urandom_range(0, 7), $urandom_range(0, 3),
                           ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 31)) - 16);
      if ($urandom_range(0, 3) == 0) begin
        bus.free_valid = 1'b1;
        bus.free_idx   = IB'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 2) == 0) begin
        bus.upd_valid        = 1'b1;
        bus.upd_idx          = IB'($urandom_range(0, 3));
        bus.upd_state_en     = 1'($urandom_range(0, 1));
        bus.upd_state        = UNSTABLE_STATE_BITS'($urandom);
        bus.upd_line_en      = 1'($urandom_range(0, 1));
        bus.upd_line         = {$urandom, $urandom, $urandom, $urandom};
        bus.upd_invack_en    = 1'($urandom_range(0, 1));
        bus.upd_invack_delta = IW'($urandom_range(0, 31));
      end
      tick("random");
    end

    @(negedge clk); rst = 1'b0; idle(); tick("pre_reset");
    @(negedge clk); rst = 1'b1; idle(); tick("pre_release");
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); idle();
      bus.alloc_valid = 1'b1; bus.alloc_entry = mk(48 + k, 2, 1);
      tick("two_alloc");
    end
    @(negedge clk); idle(); bus.lookup_tag = 13'h30; bus.lookup_set = 8'd2; tick("before_rst");
    @(negedge clk); rst = 1'b0; tick("async_rst");
    @(negedge clk); rst = 1'b1; tick("after_rst");

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d queued expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/l2_reqs_buf_ctrl.md
Name: l2_reqs_buf_ctrl

Overview:
- Parametrised ongoing-request buffer (MSHR) for the L2. It supersedes the flat reqs_buf record with a managed N-entry store.
- Provides allocate, lookup, field update and free. Lookup is by tag/set, with set-conflict detection.
- Tracks a signed inv-ack count per entry and reports completion.
- Sits between the L2 CPU-request front end and the coherence request/response handlers.

Parameters:
- N_REQS, 4: entry count; legal range 2..16.
- TAG_BITS, `L2_TAG_BITS: tag width.
- SET_BITS, `L2_SET_BITS: set-index width.
- INVACK_BITS, `INVACK_CNT_CALC_WIDTH: signed inv-ack accumulator width.
- IDX_BITS, $clog2(N_REQS): entry index width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- alloc_valid  in  1  allocation request
- alloc_ready  out  1  a free entry exists
- alloc_entry  in  REQS_ENTRY_BITS  packed reqs_entry_t to store
- alloc_idx  out  IDX_BITS  index given to the current allocation
- lookup_tag  in  TAG_BITS  tag to search
- lookup_set  in  SET_BITS  set to search
- lookup_hit  out  1  a valid entry matches tag and set
- lookup_hit_idx  out  IDX_BITS  lowest matching index
- lookup_set_conflict  out  1  a valid entry matches the set, any tag
- upd_valid  in  1  field update strobe
- upd_idx  in  IDX_BITS  target entry
- upd_state_en  in  1  write the state field
- upd_state  in  `UNSTABLE_STATE_BITS  new state
- upd_line_en  in  1  write the line field
- upd_line  in  `BITS_PER_LINE  new line
- upd_invack_en  in  1  add to the inv-ack count
- upd_invack_delta  in  INVACK_BITS  signed addend
- free_valid  in  1  release an entry
- free_idx  in  IDX_BITS  entry to release
- rd_idx  in  IDX_BITS  read port select
- rd_entry  out  REQS_ENTRY_BITS  entry contents (combinational)
- rd_valid  out  1  entry is allocated
- invack_done  out  N_REQS  per-entry flag: valid and invack count == 0
- occupancy  out  IDX_BITS+1  number of valid entries
- err_free_invalid  out  1  one-cycle pulse: free of an unallocated entry

Behaviour:
- Reset (rst=0, async): all valid bits 0; all entry fields 0.
  - Outputs at reset: occupancy=0, alloc_ready=1, alloc_idx=0, lookup_hit=0, lookup_set_conflict=0, invack_done=0, err_free_invalid=0.
- Reset asserted mid-transaction discards all entries. No drain.
- alloc_ready and alloc_idx derive from registered valid bits only. alloc_idx is the lowest free index.
  - A transfer occurs when alloc_valid & alloc_ready.
  - The entry becomes valid on the next edge, with fields from alloc_entry and invack_cnt = alloc_entry.invack_cnt.
- Lookup is purely combinational on registered state. A same-cycle allocation is not visible until the next cycle.
- Update: on upd_valid, each enabled field of entry upd_idx is written at the edge.
  - Inv-ack: invack_cnt <= invack_cnt + upd_invack_delta, two's complement, wraps at INVACK_BITS.
  - Negative counts are legal: inv-acks may precede data.
  - An update to an invalid entry is ignored.
- Free: free_valid with a valid entry clears its valid bit at the edge. Fields are retained but unused.
  - Free of an invalid entry: no state change; err_free_invalid=1 on the next cycle for one cycle.
- Simultaneous events in the same cycle:
  - Free plus alloc: a full buffer stays not-ready that cycle. The freed slot is reusable one cycle later.
  - Update plus free on the same idx: free wins.
  - Alloc never targets an entry being updated, because updates only hit valid entries.
- Full: alloc_ready=0. alloc_valid is held by the requester, with no loss.
- Empty: occupancy=0; lookup outputs 0.
- occupancy is registered: +1 on alloc, -1 on a legal free, net 0 when both occur.
- invack_done[i] is combinational from registered state.

Optional Feature:
- Macro: REQS_BUF_STATS_EN.
- With the macro defined, these extra outputs exist:
  - stat_hwm (IDX_BITS+1): occupancy high-water mark, reset 0, saturating.
  - stat_alloc_stall (32 bits): counts cycles with alloc_valid & !alloc_ready, saturating at all-ones.
  - stat_clr (input): synchronous clear of both stats.
- Without the macro, these ports and their logic are absent. All other behaviour is identical.

Decomposition:
- Package l2_reqs_buf_pkg holds:
  - reqs_entry_t: packed struct with cpu_msg, tag, tag_estall, set, way, hsize, w_off, b_off, state, hprot, invack_cnt, word, line.
  - REQS_ENTRY_BITS.
  - Field-width constants from cache_consts.
- One sub-module, reqs_buf_prio_enc: lowest-set-bit priority encoder. It is reused for free-slot selection and hit-index selection.

Test Plan:
- Reset, then 4 allocs of tags 0x10..0x13 on set 5 → idx 0,1,2,3; alloc_ready=0 after the 4th; occupancy=4.
- Lookup tag 0x12 set 5 → hit=1, hit_idx=2; lookup tag 0x99 set 5 → hit=0, set_conflict=1; set 6 → both 0.
- Full buffer: free idx 1 together with alloc_valid → no alloc that cycle; next cycle alloc_idx=1.
- Entry 0 inv-ack sequence:
  - Deltas -1, -1 → invack_cnt=-2, invack_done[0]=0.
  - Then delta +2 → invack_cnt=0, invack_done[0]=1.
- Free of unallocated idx 3 on an empty buffer → err_free_invalid pulses for 1 cycle; occupancy stays 0.
- With 2 entries valid, assert rst mid-cycle → outputs return to reset values immediately; lookup on the old tag → hit=0.
